// File: rtl/hp_arb_pkg.sv
// rtl/hp_arb_pkg.sv - shared types, constants and helpers for the headphone output arbiter
package hp_arb_pkg;

  localparam int SAMPLE_W = 24;
  localparam int STAT_W   = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_L = 2'd1,
    EMIT_R = 2'd2
  } out_state_t;

  typedef enum logic {
    EXP_L = 1'b0,
    EXP_R = 1'b1
  } asm_state_t;

  // Saturating add of a 0..2 increment to a statistics counter.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + {{(STAT_W-1){1'b0}}, inc};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/stereo_frame_assembler.sv
// rtl/stereo_frame_assembler.sv - pairs L/R beats of one source into stereo frames
module stereo_frame_assembler
  import hp_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t data,
  input  logic    channel,
  input  logic    valid,
  output frame_t  frame,
  output logic    frame_done,
  output logic    seq_err
);

  asm_state_t state_q, state_next;
  sample_t    l_q;

  // An L beat is captured in either state; in EXP_R it replaces the stale L.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EXP_L;
      l_q     <= '0;
    end else begin
      state_q <= state_next;
      if (valid && channel == CH_LEFT) l_q <= data;
    end
  end

  always_comb begin
    state_next = state_q;
    frame_done = 1'b0;
    seq_err    = 1'b0;
    if (valid) begin
      case (state_q)
        EXP_L: begin
          if (channel == CH_LEFT) state_next = EXP_R;
          else                    seq_err    = 1'b1;
        end
        EXP_R: begin
          if (channel == CH_RIGHT) begin
            frame_done = 1'b1;
            state_next = EXP_L;
          end else begin
            seq_err = 1'b1;
          end
        end
        default: state_next = EXP_L;
      endcase
    end
  end

  assign frame = {l_q, data};

endmodule

// File: rtl/headphone_out_arbiter.sv
// rtl/headphone_out_arbiter.sv - frame-aligned A/B arbiter for the headphone sink; HP_ARB_STATS_EN adds drop/sequence-error counters
module headphone_out_arbiter
  import hp_arb_pkg::*;
#(
  parameter int DATA_W         = SAMPLE_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              audio_fabric_system_clk_clk,
  input  logic              subsystem_reset_reset,
  input  logic [DATA_W-1:0] src_a_data,
  input  logic              src_a_channel,
  input  logic              src_a_valid,
  input  logic [DATA_W-1:0] src_b_data,
  input  logic              src_b_channel,
  input  logic              src_b_valid,
  input  logic              sel_b,
  output logic [DATA_W-1:0] to_headphone_out_data,
  output logic              to_headphone_out_channel,
  output logic              to_headphone_out_valid,
  output logic              active_src,
  output logic              src_timeout
`ifdef HP_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] drop_count,
  output logic [STAT_W-1:0] seq_err_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  if (DATA_W != SAMPLE_W) begin : g_width_check
    $error("DATA_W must equal hp_arb_pkg::SAMPLE_W");
  end

  logic clk, rst;
  assign clk = audio_fabric_system_clk_clk;
  assign rst = subsystem_reset_reset;

  frame_t a_frame, b_frame, grant_frame, hold_q;
  logic   a_done, b_done, a_err, b_err;
  logic   grant_done, drop_done, overrun, fire, load, do_switch, full_q;
  sample_t    emit_r_q;
  out_state_t state_q, state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] data_next;
  logic              ch_next, valid_next;

  stereo_frame_assembler u_asm_a (
    .clk(clk), .rst(rst), .data(src_a_data), .channel(src_a_channel), .valid(src_a_valid),
    .frame(a_frame), .frame_done(a_done), .seq_err(a_err)
  );

  stereo_frame_assembler u_asm_b (
    .clk(clk), .rst(rst), .data(src_b_data), .channel(src_b_channel), .valid(src_b_valid),
    .frame(b_frame), .frame_done(b_done), .seq_err(b_err)
  );

  assign grant_done  = active_src ? b_done : a_done;
  assign grant_frame = active_src ? b_frame : a_frame;
  assign drop_done   = active_src ? a_done : b_done;
  // A frame landing while IDLE copies out the old one is not an overrun.
  assign overrun     = grant_done && full_q && !load;
  assign fire        = (cnt_q == '0) && !full_q && !grant_done;

  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    do_switch  = 1'b0;
    valid_next = 1'b0;
    ch_next    = to_headphone_out_channel;
    data_next  = to_headphone_out_data;
    case (state_q)
      IDLE: begin
        if (full_q) begin
          load       = 1'b1;
          state_next = EMIT_L;
          valid_next = 1'b1;
          ch_next    = CH_LEFT;
          data_next  = hold_q.l;
        end else if (sel_b != active_src) begin
          do_switch = 1'b1;
        end
      end
      EMIT_L: begin
        state_next = EMIT_R;
        valid_next = 1'b1;
        ch_next    = CH_RIGHT;
        data_next  = emit_r_q;
      end
      EMIT_R:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                  <= IDLE;
      full_q                   <= 1'b0;
      hold_q                   <= '0;
      emit_r_q                 <= '0;
      cnt_q                    <= RELOAD;
      active_src               <= 1'b0;
      src_timeout              <= 1'b0;
      to_headphone_out_data    <= '0;
      to_headphone_out_channel <= 1'b0;
      to_headphone_out_valid   <= 1'b0;
    end else begin
      state_q                  <= state_next;
      to_headphone_out_data    <= data_next;
      to_headphone_out_channel <= ch_next;
      to_headphone_out_valid   <= valid_next;
      if (load) emit_r_q <= hold_q.r;
      if (do_switch) active_src <= sel_b;

      // A new frame (real or silence) takes priority over clearing on copy-out.
      if (grant_done) begin
        hold_q <= grant_frame;
        full_q <= 1'b1;
      end else if (fire) begin
        hold_q <= '0;
        full_q <= 1'b1;
      end else if (load) begin
        full_q <= 1'b0;
      end

      if (grant_done)      src_timeout <= 1'b0;
      else if (fire)       src_timeout <= 1'b1;

      if (grant_done || do_switch || fire) cnt_q <= RELOAD;
      else if (cnt_q != '0)                cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef HP_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count    <= '0;
      seq_err_count <= '0;
    end else begin
      drop_count    <= sat_add(drop_count, {1'b0, drop_done} + {1'b0, overrun});
      seq_err_count <= sat_add(seq_err_count, {1'b0, a_err} + {1'b0, b_err});
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{a_err, b_err, drop_done, overrun};
`endif

endmodule

// File: tb/tb_headphone_out_arbiter.sv
// tb/tb_headphone_out_arbiter.sv - directed self-checking bench for headphone_out_arbiter
module tb_headphone_out_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] a_data, b_data;
  logic        a_ch, b_ch, a_v, b_v, sel_b;
  logic [23:0] out_data;
  logic        out_ch, out_v, active_src, src_timeout;
`ifdef HP_ARB_STATS_EN
  logic [15:0] drop_count, seq_err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  headphone_out_arbiter #(.DATA_W(24), .TIMEOUT_CYCLES(8)) dut (
    .audio_fabric_system_clk_clk(clk),
    .subsystem_reset_reset(rst),
    .src_a_data(a_data), .src_a_channel(a_ch), .src_a_valid(a_v),
    .src_b_data(b_data), .src_b_channel(b_ch), .src_b_valid(b_v),
    .sel_b(sel_b),
    .to_headphone_out_data(out_data),
    .to_headphone_out_channel(out_ch),
    .to_headphone_out_valid(out_v),
    .active_src(active_src),
    .src_timeout(src_timeout)
`ifdef HP_ARB_STATS_EN
    ,
    .drop_count(drop_count),
    .seq_err_count(seq_err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output beat packed as {valid, channel, data}.
  task automatic check_beat(input string tag, input logic v, input logic ch, input logic [23:0] d);
    check(tag, {6'b0, out_v, out_ch, out_data}, {6'b0, v, ch, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic set_a(input logic ch, input logic [23:0] d);
    a_v = 1'b1; a_ch = ch; a_data = d;
  endtask

  task automatic set_b(input logic ch, input logic [23:0] d);
    b_v = 1'b1; b_ch = ch; b_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; sel_b = 1'b0;
    a_v = 1'b0; a_ch = 1'b0; a_data = '0;
    b_v = 1'b0; b_ch = 1'b0; b_data = '0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  logic [25:0] ovr_exp [1:11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state and single frame from A
    do_reset();
    check_beat("reset_out", 1'b0, 1'b0, 24'h0);
    check("reset_active", {31'b0, active_src}, 32'd0);
    check("reset_timeout", {31'b0, src_timeout}, 32'd0);
    set_a(1'b0, 24'h123456); step();
    set_a(1'b1, 24'hABCDEF); step();
    check_beat("single_n1", 1'b0, 1'b0, 24'h0);
    step(); check_beat("single_l", 1'b1, 1'b0, 24'h123456);
    step(); check_beat("single_r", 1'b1, 1'b1, 24'hABCDEF);
    step(); check_beat("single_hold", 1'b0, 1'b1, 24'hABCDEF);
    check("single_active", {31'b0, active_src}, 32'd0);

    // Timeout: silence frame after 8 idle cycles, then a real frame clears it
    do_reset();
    repeat (7) step();
    check("to_not_yet", {31'b0, src_timeout}, 32'd0);
    step();
    check("to_set", {31'b0, src_timeout}, 32'd1);
    step(); check_beat("to_zero_l", 1'b1, 1'b0, 24'h0);
    step(); check_beat("to_zero_r", 1'b1, 1'b1, 24'h0);
    set_a(1'b0, 24'h0A0B0C); step();
    check_beat("to_gap", 1'b0, 1'b1, 24'h0);
    set_a(1'b1, 24'h0D0E0F); step();
    check("to_clear", {31'b0, src_timeout}, 32'd0);
    step(); check_beat("to_real_l", 1'b1, 1'b0, 24'h0A0B0C);
    step(); check_beat("to_real_r", 1'b1, 1'b1, 24'h0D0E0F);

    // Switch to B while A's frame is pending; B's partial frame is kept
    do_reset();
    set_a(1'b0, 24'h111111); set_b(1'b0, 24'h000001); step();
    set_a(1'b1, 24'h222222); set_b(1'b1, 24'h000002); step();
    check_beat("sw_pending", 1'b0, 1'b0, 24'h0);
`ifdef HP_ARB_STATS_EN
    check("sw_drop1", {16'b0, drop_count}, 32'd1);
`endif
    sel_b = 1'b1;
    step(); check_beat("sw_a_l", 1'b1, 1'b0, 24'h111111);
    check("sw_active_e3", {31'b0, active_src}, 32'd0);
    set_b(1'b0, 24'h000003);
    step(); check_beat("sw_a_r", 1'b1, 1'b1, 24'h222222);
    step(); check("sw_active_e5", {31'b0, active_src}, 32'd0);
    step(); check("sw_active_e6", {31'b0, active_src}, 32'd1);
    set_b(1'b1, 24'h000004); step();
    check_beat("sw_gap", 1'b0, 1'b1, 24'h222222);
    step(); check_beat("sw_b_l", 1'b1, 1'b0, 24'h000003);
    step(); check_beat("sw_b_r", 1'b1, 1'b1, 24'h000004);
`ifdef HP_ARB_STATS_EN
    check("sw_drop_final", {16'b0, drop_count}, 32'd1);
`endif

    // Sequence errors: R, R, L, L, R
    do_reset();
    set_a(1'b1, 24'hBAD001); step();
    set_a(1'b1, 24'hBAD002); step();
    set_a(1'b0, 24'h0000AA); step();
    set_a(1'b0, 24'h0000BB); step();
    set_a(1'b1, 24'h0000CC); step();
`ifdef HP_ARB_STATS_EN
    check("seq_count", {16'b0, seq_err_count}, 32'd3);
    check("seq_drop", {16'b0, drop_count}, 32'd0);
`endif
    check_beat("seq_none_yet", 1'b0, 1'b0, 24'h0);
    step(); check_beat("seq_l", 1'b1, 1'b0, 24'h0000BB);
    step(); check_beat("seq_r", 1'b1, 1'b1, 24'h0000CC);
    step(); check_beat("seq_hold", 1'b0, 1'b1, 24'h0000CC);

    // Overrun: frames every 2 cycles, frame 3 is overwritten by frame 4
    do_reset();
    ovr_exp[1]  = {2'b00, 24'h000000};
    ovr_exp[2]  = {2'b00, 24'h000000};
    ovr_exp[3]  = {2'b10, 24'h100001};
    ovr_exp[4]  = {2'b11, 24'h200001};
    ovr_exp[5]  = {2'b01, 24'h200001};
    ovr_exp[6]  = {2'b10, 24'h100002};
    ovr_exp[7]  = {2'b11, 24'h200002};
    ovr_exp[8]  = {2'b01, 24'h200002};
    ovr_exp[9]  = {2'b10, 24'h100004};
    ovr_exp[10] = {2'b11, 24'h200004};
    ovr_exp[11] = {2'b01, 24'h200004};
    for (int i = 1; i <= 11; i++) begin
      if (i <= 8) begin
        if (i % 2 == 1) set_a(1'b0, 24'h100000 + 24'((i + 1) / 2));
        else            set_a(1'b1, 24'h200000 + 24'(i / 2));
      end
      step();
      check($sformatf("ovr_c%0d", i), {6'b0, out_v, out_ch, out_data}, {6'b0, ovr_exp[i]});
    end
`ifdef HP_ARB_STATS_EN
    check("ovr_drop", {16'b0, drop_count}, 32'd1);
`endif

    // Reset asserted during EMIT_L abandons the pair
    do_reset();
    set_a(1'b0, 24'h5A5A5A); step();
    set_a(1'b1, 24'hA5A5A5); step();
    step(); check_beat("rst_emit_l", 1'b1, 1'b0, 24'h5A5A5A);
    #2;
    rst = 1'b1;
    #1;
    check_beat("rst_async", 1'b0, 1'b0, 24'h0);
    step(); step();
    rst = 1'b0;
    step(); check_beat("rst_no_r1", 1'b0, 1'b0, 24'h0);
    step(); check_beat("rst_no_r2", 1'b0, 1'b0, 24'h0);
    check("rst_active", {31'b0, active_src}, 32'd0);
    check("rst_timeout", {31'b0, src_timeout}, 32'd0);
`ifdef HP_ARB_STATS_EN
    check("rst_drop", {16'b0, drop_count}, 32'd0);
    check("rst_seq", {16'b0, seq_err_count}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/headphone_out_arbiter.md
# headphone_out_arbiter

Frame-aligned arbiter that shares the codec's `to_headphone_out` Avalon-ST sink (24-bit data, 1-bit channel, valid, no ready) between two stereo sources, A (line-in passthrough) and B (processed path). It sits between the fabric processing blocks and the AD1939 subsystem. Each source is assembled into left/right frames, and only the granted source's frames are forwarded. The grant changes only at a frame boundary, so L/R are never swapped or split. When the granted source stalls, the block substitutes silence frames.

## Interface
- `DATA_W`, 24, sample width in bits.
- `TIMEOUT_CYCLES`, 4096, cycles without a granted frame before silence is inserted. This is two 48 kHz frame periods at 98.304 MHz. Minimum value 4.
- `audio_fabric_system_clk_clk`  in  1  sole clock; all logic is on its rising edge.
- `subsystem_reset_reset`  in  1  asynchronous, active-high reset.
- `src_a_data` / `src_a_channel` / `src_a_valid`  in  DATA_W/1/1  source A stream; channel 0 = left, 1 = right.
- `src_b_data` / `src_b_channel` / `src_b_valid`  in  DATA_W/1/1  source B stream.
- `sel_b`  in  1  requested source (0 = A, 1 = B); level, may change any cycle.
- `to_headphone_out_data` / `to_headphone_out_channel` / `to_headphone_out_valid`  out  DATA_W/1/1  registered output stream.
- `active_src`  out  1  current grant (0 = A, 1 = B).
- `src_timeout`  out  1  high while silence is being substituted.

## Operation
- **Per-source assembler.** States `EXP_L` and `EXP_R`.
  - Valid with ch 0 in `EXP_L`: store L, go to `EXP_R`.
  - Valid with ch 1 in `EXP_R`: frame complete, go to `EXP_L`.
  - Valid with ch 1 in `EXP_L`: discard; this is a sequence error.
  - Valid with ch 0 in `EXP_R`: overwrite L and stay in `EXP_R`; this is a sequence error.
- **Frame from granted source.** A completed frame writes `{L, R}` into the holding register in the same edge as the R beat, and sets `full`.
  - If `full` was already set, the new frame overwrites the old one; this is an overrun.
  - A completed frame from the non-granted source is dropped.
- **Output FSM states:** `IDLE`, `EMIT_L`, `EMIT_R`.
  - `IDLE` with `full`: copy holding into output regs, clear `full`, go to `EMIT_L`.
  - `IDLE` with `!full` and `sel_b != active_src`: `active_src <= sel_b`, reload the timeout counter, stay in `IDLE`.
  - `EMIT_L`: drive valid=1, ch=0, data=L; next state `EMIT_R`.
  - `EMIT_R`: drive valid=1, ch=1, data=R; next state `IDLE`.
  - In every other cycle: valid=0, and data/channel hold their last value.
- **Grant priority.** A pending frame is always emitted before a switch. The new source's partially assembled frame is kept; its next completed frame is the first one forwarded.
- **Timeout counter.**
  - Reloads to `TIMEOUT_CYCLES-1` on every granted frame completion and on every grant switch.
  - Decrements otherwise.
  - At 0 with `!full`: write a zero frame into holding, set `src_timeout`, reload.
  - `src_timeout` clears on the next real granted frame completion.
- **Reset values:** all outputs 0, `active_src` = 0 (A), assemblers in `EXP_L`, `full` = 0, FSM in `IDLE`, counter = `TIMEOUT_CYCLES-1`.
- **Reset mid-operation:** partial frames and pending frames are discarded. If reset asserts between `EMIT_L` and `EMIT_R`, the half-emitted pair is abandoned and no R beat follows.

## Timing
- Granted R beat sampled in cycle N: `full` is visible in N+1, the L beat appears in N+2, the R beat in N+3, and the FSM is back in `IDLE` in N+4.
- The output always carries exactly one L beat followed by one R beat, on consecutive cycles.
- Sustained throughput: one frame per 3 cycles. Faster input produces overruns, with last-frame-wins.
- Simultaneous completions from A and B in the same cycle: only the granted one is captured.
- A `sel_b` change takes effect on the first `IDLE` cycle with `!full`. It is visible on `active_src` one cycle later.

## Configuration
- `HP_ARB_STATS_EN` defined: adds two outputs.
  - `drop_count[15:0]`: counts non-granted completions plus overruns.
  - `seq_err_count[15:0]`: counts sequence errors from both assemblers.
  - Both saturate at 0xFFFF and clear only on reset.
  - If both assemblers report errors in the same cycle, the count increases by 2, subject to saturation.
- `HP_ARB_STATS_EN` undefined: these ports and their counters are absent; all other behaviour is identical.

## Structure
- Package `hp_arb_pkg` contains:
  - `sample_t` and `frame_t` (struct `{l, r}`);
  - `out_state_t` (`IDLE` / `EMIT_L` / `EMIT_R`) and `asm_state_t` (`EXP_L` / `EXP_R`);
  - `CH_LEFT = 1'b0`, `CH_RIGHT = 1'b1`;
  - `STAT_W = 16`.
- Sub-module `stereo_frame_assembler`, instantiated once per source. Outputs: `frame`, `frame_done` pulse, `seq_err` pulse.

## Test plan
- **Single frame, A granted.** A sends L=0x123456 then R=0xABCDEF. Required: output L beat 2 cycles after the R input, then the R beat; `active_src`=0.
- **Switch mid-frame.** `sel_b`=1 while A's frame is pending and B sends L=0x000001/R=0x000002. Required: A's frame is emitted first, then `active_src`=1, then B's next full frame is forwarded. Non-granted B completions increment `drop_count`.
- **Sequence errors.** Source A sends R, R, L, L, R. Required: one frame is forwarded, containing the second L; `seq_err_count`=3.
- **Timeout.** Granted source silent for `TIMEOUT_CYCLES`=8. Required: zero frame (ch 0 then ch 1) and `src_timeout`=1. A real frame then clears `src_timeout` and is forwarded.
- **Overrun.** Granted frames completed on back-to-back 2-cycle spacing. Required: last-frame-wins; `drop_count` increments; output pairs are never split.
- **Reset.** Reset asserted during `EMIT_L`. Required: valid=0 immediately and no R beat. After release, `active_src`=0 and all outputs are 0.
